// File: rtl/data_mem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Request and response each use their own valid/ready handshake.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one request, WAIT_CYCLES of latency, one registered response.
// Define DATA_MEM_ERR_CHECK_EN to fault misaligned/out-of-range accesses instead of wrapping.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  accept, execute, fault, mem_we;
  logic                  is_byte, is_half, is_word;
  logic [1:0]            eff_lane;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           old_word, shifted, load_data, wdata_rep, new_word;
  logic [3:0]            be;

  assign accept  = (state_q == StIdle) && bus.req_valid;
  assign execute = (state_q == StWait) && (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = StWait;
      StWait:  if (cnt_q == 4'd0) state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rdata_q;
    bus.rsp_error = error_q;
  end

  assign is_byte  = (size_q == 2'b00);
  assign is_half  = (size_q == 2'b01);
  assign is_word  = size_q[1];
  assign word_idx = addr_q[ADDR_WIDTH+1:2];

`ifdef DATA_MEM_ERR_CHECK_EN
  assign fault = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00)) ||
                 (|addr_q[31:ADDR_WIDTH+2]);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:ADDR_WIDTH+2];
  assign fault          = 1'b0;
`endif

  // Lane selection force-aligns halves and words; a faulting access never reaches memory.
  always_comb begin
    eff_lane  = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata_q;
    if (is_byte) begin
      eff_lane  = addr_q[1:0];
      be        = 4'b0001 << addr_q[1:0];
      wdata_rep = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      eff_lane  = {addr_q[1], 1'b0};
      be        = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    old_word = mem[word_idx];
    shifted  = old_word >> {eff_lane, 3'b000};
    if (is_byte) begin
      load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
    end else begin
      load_data = old_word;
    end
    for (int i = 0; i < 4; i++) begin
      new_word[8*i +: 8] = be[i] ? wdata_rep[8*i +: 8] : old_word[8*i +: 8];
    end
  end

  // Reset gating keeps a store caught by reset from landing.
  assign mem_we = execute && write_q && !fault && !reset;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[word_idx] <= new_word;
    end
  end

  // Request latch, latency counter and registered response
  always_comb begin
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) begin
      cnt_d   = 4'(WAIT_CYCLES);
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
    end else if (state_q == StWait && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (execute) begin
      rdata_d = (write_q || fault) ? 32'd0 : load_data;
      error_d = fault;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;
  localparam int AW = 10;
  localparam int WC = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  data_mem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mb [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, aligned/wrapped or faulted by access size
  function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input bit uns,
                                output logic [31:0] rd, output bit err);
    int unsigned n;
    int unsigned base;
    logic [31:0] v;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rd  = 32'd0;
    err = 1'b0;
`ifdef DATA_MEM_ERR_CHECK_EN
    if ((addr % n) != 0 || addr >= 32'(4 * (2 ** AW))) begin
      err = 1'b1;
      return;
    end
`endif
    base = (addr - (addr % n)) % (4 * (2 ** AW));
    if (wr) begin
      for (int i = 0; i < int'(n); i++) mb[int'(base) + i] = wdata[8*i +: 8];
      return;
    end
    v = 32'd0;
    for (int i = 0; i < int'(n); i++) v[8*i +: 8] = mb[int'(base) + i];
    if (n < 4 && !uns && v[8*n-1]) begin
      for (int i = 8 * int'(n); i < 32; i++) v[i] = 1'b1;
    end
    rd = v;
  endfunction

  task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input bit uns);
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
  endtask

  // Full transaction on the main DUT; checks latency and data against the model
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns,
                        output logic [31:0] rd, output logic err);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          w;
    int          lat;
    model(wr, addr, wdata, size, uns, exp_rd, exp_err);
    @(negedge clock);
    drive_req(wr, addr, wdata, size, uns);
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 40);
    chk("latency", 32'(lat), 32'(WC + 1));
    rd  = bus.rsp_rdata;
    err = bus.rsp_error;
    chk("rdata", rd, exp_rd);
    chk("rsp_error", 32'(err), 32'(exp_err));
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic txn0(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output int lat);
    @(negedge clock);
    bus0.req_write    = wr;
    bus0.req_addr     = addr;
    bus0.req_wdata    = wdata;
    bus0.req_size     = 2'd2;
    bus0.req_unsigned = 1'b0;
    bus0.req_valid    = 1'b1;
    @(posedge clock);
    #1 bus0.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus0.rsp_valid !== 1'b1 && lat < 40);
    rd = bus0.rsp_rdata;
    bus0.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus0.rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [31:0] a;

    bus.req_valid  = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size   = 2'd0; bus.req_unsigned = 1'b0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.req_size  = 2'd0; bus0.req_unsigned = 1'b0; bus0.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_error", 32'(bus.rsp_error), 32'd0);

    // Fill the low 256 bytes so every later load reads defined data
    for (int w = 0; w < 64; w++) do_txn(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, rd, err);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd, err);
    do_txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);
    do_txn(1'b1, 32'h11, 32'h123456AA, 2'd0, 1'b0, rd, err);
    chk("sb_rdata_zero", rd, 32'd0);
    do_txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err);
    chk("lw_after_sb", rd, 32'hDEADAAEF);
    do_txn(1'b0, 32'h11, 32'h0, 2'd0, 1'b0, rd, err);
    chk("lb", rd, 32'hFFFFFFAA);
    do_txn(1'b0, 32'h11, 32'h0, 2'd0, 1'b1, rd, err);
    chk("lbu", rd, 32'h000000AA);
    do_txn(1'b1, 32'h12, 32'hCAFE8001, 2'd1, 1'b0, rd, err);
    do_txn(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, rd, err);
    chk("lw_after_sh", rd, 32'h8001AAEF);
    do_txn(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, rd, err);
    chk("lh", rd, 32'hFFFF8001);
    do_txn(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd, err);
    chk("lhu", rd, 32'h00008001);
    do_txn(1'b0, 32'h13, 32'h0, 2'd2, 1'b0, rd, err);
`ifdef DATA_MEM_ERR_CHECK_EN
    chk("lw13_err", 32'(err), 32'd1);
    chk("lw13_rdata", rd, 32'd0);
`else
    chk("lw13_err", 32'(err), 32'd0);
    chk("lw13_rdata", rd, 32'h8001AAEF);
`endif

    // Backpressure with a second request waiting
    @(negedge clock);
    drive_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    @(posedge clock);
    #1 drive_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b1);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 40);
    chk("bp_latency", 32'(lat), 32'(WC + 1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata", bus.rsp_rdata, 32'h8001AAEF);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    chk("bp_second_accepted", 32'(bus.req_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 40);
    chk("bp2_latency", 32'(lat), 32'(WC + 1));
    chk("bp2_rdata", bus.rsp_rdata, 32'h00008001);
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;

    // Reset while a store sits in WAIT
    do_txn(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, rd, err);
    do_txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err);
    @(negedge clock);
    drive_req(1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    chk("mid_rst_error", 32'(bus.rsp_error), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    #1 chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    do_txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, err);
    chk("lw_after_rst", rd, 32'd0);

    // Randomized traffic; occasional high addresses exercise wrap or fault
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = ($urandom << 12) | 32'h1000 | a;
      do_txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), rd, err);
    end

    // Zero-latency instance
    txn0(1'b1, 32'h8, 32'h0BADF00D, rd, lat);
    chk("wc0_sw_latency", 32'(lat), 32'd1);
    txn0(1'b0, 32'h8, 32'h0, rd, lat);
    chk("wc0_lw_latency", 32'(lat), 32'd1);
    chk("wc0_lw_rdata", rd, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
